stream_pixel_expander: RTL and testbench

- Parametrised, registered successor to the combinational pixel width expander in the camera-to-VGA image stream path.
- Widens each of CHANNELS colour channels from IN_BITS to OUT_BITS using true MSB replication or zero padding, chosen per beat.
- Optionally reverses channel order.
- Provides a 2-entry skid buffer so Avalon-ST backpressure is fully registered, with zero bubbles at full throughput.

---
 rtl/stream_pixel_expander.sv | 190 +++++++++++++++++++
 tb/tb_stream_pixel_expander.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pixel_expander.sv
// Registered pixel channel expander (replicate / zero-pad, optional channel swap) with a 2-entry skid buffer.
// Optional frame length checker enabled by defining STREAM_PIXEL_EXPANDER_FRAME_CHECK_EN.
module stream_pixel_expander #(
    parameter int CHANNELS     = 3,
    parameter int IN_BITS      = 4,
    parameter int OUT_BITS     = 10,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*IN_BITS-1:0]  data_in,
    input  logic                         sop_in,
    input  logic                         eop_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic                         mode_in,
    input  logic                         swap_in,
    output logic [CHANNELS*OUT_BITS-1:0] data_out,
    output logic                         sop_out,
    output logic                         eop_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         frame_err_out
);

    localparam int DW = CHANNELS * OUT_BITS;
    localparam int PW = DW + 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    generate
        if (OUT_BITS < IN_BITS) begin : g_bad_width
            $error("stream_pixel_expander: OUT_BITS must be >= IN_BITS");
        end
        if (FRAME_PIXELS < 1) begin : g_bad_frame
            $error("stream_pixel_expander: FRAME_PIXELS must be >= 1");
        end
    endgenerate

    function automatic logic [OUT_BITS-1:0] expand_channel(input logic [IN_BITS-1:0] ch,
                                                           input logic zero_pad);
        logic [OUT_BITS-1:0] res;
        res = '0;
        if (zero_pad) begin
            res[OUT_BITS-1 -: IN_BITS] = ch;
        end else begin
            for (int k = 0; k < OUT_BITS; k++) begin
                res[OUT_BITS-1-k] = ch[IN_BITS-1-(k % IN_BITS)];
            end
        end
        return res;
    endfunction

    state_t        state_r, state_nxt_s;
    logic [PW-1:0] or_r, or_nxt_s;
    logic [PW-1:0] sk_r, sk_nxt_s;
    logic [DW-1:0] exp_data_s;
    logic [PW-1:0] new_beat_s;
    logic          in_xfer_s;

    // Per-channel swap then expansion of the incoming pixel.
    always_comb begin
        exp_data_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            exp_data_s[c*OUT_BITS +: OUT_BITS] = expand_channel(
                swap_in ? data_in[(CHANNELS-1-c)*IN_BITS +: IN_BITS]
                        : data_in[c*IN_BITS +: IN_BITS],
                mode_in);
        end
    end

    // Skid storage is the only thing that can block the input; no path from ready_in.
    assign ready_out  = !state_r[1] && !reset;
    assign in_xfer_s  = valid_in && ready_out;
    assign new_beat_s = {exp_data_s, sop_in, eop_in};

    // Next-state and payload steering for the output/skid register pair.
    always_comb begin
        state_nxt_s = state_r;
        or_nxt_s    = or_r;
        sk_nxt_s    = sk_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    or_nxt_s    = new_beat_s;
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && ready_in) begin
                    or_nxt_s    = new_beat_s;
                    state_nxt_s = ST_ONE;
                end else if (in_xfer_s) begin
                    sk_nxt_s    = new_beat_s;
                    state_nxt_s = ST_FULL;
                end else if (ready_in) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (ready_in) begin
                    or_nxt_s    = sk_r;
                    sk_nxt_s    = '0;
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                or_nxt_s    = '0;
                sk_nxt_s    = '0;
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State and payload registers; reset discards any in-flight beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            or_r    <= '0;
            sk_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            or_r    <= or_nxt_s;
            sk_r    <= sk_nxt_s;
        end
    end

    assign valid_out = state_r[0];
    assign data_out  = or_r[PW-1:2];
    assign sop_out   = or_r[1];
    assign eop_out   = or_r[0];

`ifdef STREAM_PIXEL_EXPANDER_FRAME_CHECK_EN
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_PIXELS);

    logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_adv_s;
    logic          out_xfer_s, err_s, frame_err_r;

    assign out_xfer_s = valid_out && ready_in;

    // Frame length bookkeeping on output transfers; a non-zero count means a frame is open.
    always_comb begin
        if (sop_out) begin
            cnt_adv_s = CW'(1);
        end else if (cnt_r == CNT_MAX) begin
            cnt_adv_s = cnt_r;
        end else begin
            cnt_adv_s = cnt_r + CW'(1);
        end
        if (out_xfer_s && eop_out) begin
            cnt_nxt_s = '0;
            err_s     = (sop_out && (cnt_r != '0)) || (cnt_adv_s != FRAME_CNT);
        end else if (out_xfer_s) begin
            cnt_nxt_s = cnt_adv_s;
            err_s     = sop_out && (cnt_r != '0);
        end else begin
            cnt_nxt_s = cnt_r;
            err_s     = 1'b0;
        end
    end

    // Pixel counter and one-cycle error pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= '0;
            frame_err_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            frame_err_r <= err_s;
        end
    end

    assign frame_err_out = frame_err_r;
`else
    assign frame_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_stream_pixel_expander.sv
// Scoreboard bench for stream_pixel_expander: random and directed stimulus against a arithmetic reference model.
// Frame checks are exercised when STREAM_PIXEL_EXPANDER_FRAME_CHECK_EN is defined.
module tb_stream_pixel_expander;

    localparam int CH = 3;
    localparam int IW = 4;
    localparam int OW = 10;
    localparam int FP = 8;

    typedef struct {
        logic [CH*OW-1:0] d;
        logic             sop;
        logic             eop;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [CH*IW-1:0] data_in = '0;
    logic             sop_in = 1'b0;
    logic             eop_in = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic             mode_in = 1'b0;
    logic             swap_in = 1'b0;
    logic [CH*OW-1:0] data_out;
    logic             sop_out;
    logic             eop_out;
    logic             valid_out;
    logic             ready_in = 1'b1;
    logic             frame_err_out;

    logic rin_rand = 1'b0;
    logic rin_val  = 1'b1;

    int    checks = 0;
    int    errors = 0;
    int    stalls = 0;
    int    pulses = 0;
    beat_t exp_q[$];

    stream_pixel_expander #(
        .CHANNELS(CH), .IN_BITS(IW), .OUT_BITS(OW), .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(ready_out), .mode_in(mode_in), .swap_in(swap_in),
        .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out), .valid_out(valid_out),
        .ready_in(ready_in), .frame_err_out(frame_err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ready_in = rin_rand ? 1'($urandom_range(0, 1)) : rin_val;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Replication as a repeated bit pattern, truncated to the top OW bits.
    function automatic logic [OW-1:0] ref_channel(input logic [IW-1:0] v, input logic zp);
        longint rep;
        int     n;
        if (zp) return OW'(longint'(v) << (OW - IW));
        n   = (OW + IW - 1) / IW;
        rep = 0;
        for (int i = 0; i < n; i++) rep = (rep << IW) | longint'(v);
        return OW'(rep >> (n * IW - OW));
    endfunction

    function automatic logic [CH*OW-1:0] ref_pixel(input logic [CH*IW-1:0] din,
                                                   input logic m, input logic s);
        logic [CH*OW-1:0] res;
        int               src;
        res = '0;
        for (int c = 0; c < CH; c++) begin
            src = s ? (CH - 1 - c) : c;
            res[c*OW +: OW] = ref_channel(din[src*IW +: IW], m);
        end
        return res;
    endfunction

    // Monitor and scoreboard, sampled on the falling edge.
    logic        held_v = 1'b0;
    logic [63:0] held_val = '0;
    logic        err_pend = 1'b0;
    int          fr_beats = 0;
    always @(negedge clk) begin
        int    occ;
        beat_t b;
        logic  e;
        if (reset) begin
            chk("rst_valid_out", 64'(valid_out), 64'd0);
            chk("rst_ready_out", 64'(ready_out), 64'd0);
            chk("rst_data_out", 64'(data_out), 64'd0);
            chk("rst_sop_eop", 64'({sop_out, eop_out}), 64'd0);
            chk("rst_frame_err", 64'(frame_err_out), 64'd0);
            exp_q.delete();
            held_v   = 1'b0;
            err_pend = 1'b0;
            fr_beats = 0;
        end else begin
            occ = exp_q.size();
            chk("ready_out_vs_fill", 64'(ready_out), 64'(occ < 2));
            chk("valid_out_vs_fill", 64'(valid_out), 64'(occ > 0));
            chk("frame_err_out", 64'(frame_err_out), 64'(err_pend));
            if (frame_err_out) pulses++;
            err_pend = 1'b0;
            if (held_v) chk("stall_hold", 64'({valid_out, data_out, sop_out, eop_out}), held_val);
            held_v   = valid_out && !ready_in;
            held_val = 64'({valid_out, data_out, sop_out, eop_out});
            if (valid_out && ready_in && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("out_data", 64'(data_out), 64'(b.d));
                chk("out_sop_eop", 64'({sop_out, eop_out}), 64'({b.sop, b.eop}));
`ifdef STREAM_PIXEL_EXPANDER_FRAME_CHECK_EN
                e = 1'b0;
                if (b.sop) begin
                    e = (fr_beats != 0);
                    fr_beats = 1;
                end else begin
                    fr_beats++;
                end
                if (b.eop) begin
                    if (fr_beats != FP) e = 1'b1;
                    fr_beats = 0;
                end
                err_pend = e;
`else
                e = 1'b0;
                err_pend = e;
`endif
            end
            if (valid_in && ready_out)
                exp_q.push_back('{ref_pixel(data_in, mode_in, swap_in), sop_in, eop_in});
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [CH*IW-1:0] d, input logic m, input logic s,
                        input logic so, input logic eo);
        int   n;
        logic acc;
        n = 0;
        data_in = d; mode_in = m; swap_in = s; sop_in = so; eop_in = eo; valid_in = 1'b1;
        do begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #2;
            if (!acc) begin
                stalls++;
                n++;
            end
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CH*OW-1:0] dir_exp[3];
        dir_exp[0] = {10'h3FF, 10'h2AA, 10'h044};
        dir_exp[1] = {10'h3C0, 10'h280, 10'h040};
        dir_exp[2] = {10'h044, 10'h2AA, 10'h3FF};

        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(ready_out), 64'd1);
        sync();

        // Directed expansion vectors at full rate.
        for (int i = 0; i < 3; i++) begin
            send(12'hFA1, (i == 1), (i == 2), 1'b0, 1'b0);
            @(negedge clk);
            chk("dir_valid", 64'(valid_out), 64'd1);
            chk("dir_data", 64'(data_out), 64'(dir_exp[i]));
            sync();
        end

        // Full throughput: no stalls with ready_in held high.
        stalls = 0;
        for (int i = 0; i < 20; i++)
            send(12'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("throughput_stalls", 64'(stalls), 64'd0);

        // Ordered stream under random backpressure.
        rin_rand = 1'b1;
        for (int i = 0; i < 20; i++)
            send(12'(i), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            send(12'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) sync();
        end
        rin_rand = 1'b0;
        rin_val  = 1'b1;
        repeat (6) sync();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Three-cycle ready_in drop with continuous valid_in.
        @(negedge clk);
        rin_val = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk);
                rin_val = 1'b1;
            end
        join_none
        sync();
        stalls = 0;
        for (int i = 0; i < 4; i++)
            send(12'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_stalls", 64'(stalls), 64'd2);
        repeat (4) sync();

        // Reset while FULL.
        rin_val = 1'b0;
        repeat (2) sync();
        send(12'h123, 1'b0, 1'b0, 1'b1, 1'b0);
        send(12'h456, 1'b0, 1'b0, 1'b0, 1'b0);
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 12'h789;
        @(negedge clk);
        chk("full_rst_valid", 64'(valid_out), 64'd0);
        chk("full_rst_ready", 64'(ready_out), 64'd0);
        repeat (2) sync();
        valid_in = 1'b0;
        reset    = 1'b0;
        rin_val  = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(ready_out), 64'd1);
        sync();
        send(12'hFA1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("release_first_valid", 64'(valid_out), 64'd1);
        chk("release_first_data", 64'(data_out), 64'(dir_exp[0]));
        sync();

`ifdef STREAM_PIXEL_EXPANDER_FRAME_CHECK_EN
        reset = 1'b1;
        sync();
        reset = 1'b0;
        sync();
        pulses = 0;
        for (int i = 0; i < 7; i++)
            send(12'($urandom), 1'b0, 1'b0, (i == 0), (i == 6));
        for (int i = 0; i < 8; i++)
            send(12'($urandom), 1'b0, 1'b0, (i == 0), (i == 7));
        for (int i = 0; i < 3; i++)
            send(12'($urandom), 1'b0, 1'b0, (i == 0), 1'b0);
        for (int i = 0; i < 8; i++)
            send(12'($urandom), 1'b0, 1'b0, (i == 0), (i == 7));
        repeat (3) sync();
        chk("frame_pulse_count", 64'(pulses), 64'd2);
`endif

        repeat (3) sync();
        chk("final_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
